// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if: receiver-side byte stream in, key events out.
// master = byte source / event consumer, slave = controller.
interface ps2_kbd_ctrl_if;
    logic       in_valid;
    logic [7:0] in_code;
    logic       in_parity_err;
    logic       in_frame_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       overflow;
    logic [7:0] err_cnt;

    modport master (
        output in_valid, in_code, in_parity_err, in_frame_err,
        output evt_ready,
        input  evt_valid, evt_code, evt_ext, evt_break,
        input  overflow, err_cnt
    );

    modport slave (
        input  in_valid, in_code, in_parity_err, in_frame_err,
        input  evt_ready,
        output evt_valid, evt_code, evt_ext, evt_break,
        output overflow, err_cnt
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: collapses set-2 E0/F0 prefixes into key events, FIFO out.
// Optional prefix timeout enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_kbd_ctrl_if.slave  kbd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GOT_E0,
        S_GOT_F0,
        S_GOT_E0F0
    } state_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_push;
    logic         w_ext;
    logic         w_brk;
    logic         w_err;
    logic         w_tmo;
    logic         w_bad;
    logic         w_is_e0;
    logic         w_is_f0;
    logic         w_is_key;

    logic [9:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]  r_cnt;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_wr;
    logic         w_drop;
    logic [9:0]   w_head;

    logic         r_overflow;
    logic [7:0]   r_err_cnt;

    // Mutually exclusive byte classes; bad bytes win over everything.
    assign w_bad = kbd.in_parity_err | kbd.in_frame_err
                 | (kbd.in_code == 8'h00) | (kbd.in_code == 8'hFF);
    assign w_is_e0  = ~w_bad & (kbd.in_code == 8'hE0);
    assign w_is_f0  = ~w_bad & (kbd.in_code == 8'hF0);
    assign w_is_key = ~w_bad & ~w_is_e0 & ~w_is_f0;

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;

    // Cycles spent waiting inside a prefix; any byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || kbd.in_valid || r_state == S_IDLE)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    assign w_tmo = (r_state != S_IDLE)
                 & (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout a prefix waits forever.
    assign w_tmo = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Decoder next state, event generation and error strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ext       = 1'b0;
        w_brk       = 1'b0;
        w_err       = 1'b0;
        if (kbd.in_valid) begin
            unique case (1'b1)
                w_bad: begin
                    w_state_nxt = S_IDLE;
                    w_err       = 1'b1;
                end
                w_is_e0: begin
                    w_state_nxt = S_GOT_E0;
                    w_err       = (r_state != S_IDLE);
                end
                w_is_f0: begin
                    if (r_state == S_IDLE)
                        w_state_nxt = S_GOT_F0;
                    else if (r_state == S_GOT_E0)
                        w_state_nxt = S_GOT_E0F0;
                end
                w_is_key: begin
                    w_push      = 1'b1;
                    w_ext       = (r_state == S_GOT_E0)
                                | (r_state == S_GOT_E0F0);
                    w_brk       = (r_state == S_GOT_F0)
                                | (r_state == S_GOT_E0F0);
                    w_state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end else if (w_tmo) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & kbd.evt_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Event storage; entries are {ext, break, code}.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= {w_ext, w_brk, kbd.in_code};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_wr && !w_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (!w_wr && w_pop)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

    // Sticky drop flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'h00;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign kbd.evt_valid = ~w_empty;
    assign kbd.evt_code  = w_empty ? 8'h00 : w_head[7:0];
    assign kbd.evt_break = ~w_empty & w_head[8];
    assign kbd.evt_ext   = ~w_empty & w_head[9];
    assign kbd.overflow  = r_overflow;
    assign kbd.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed scenarios for the keyboard controller.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_ps2_kbd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    ps2_kbd_ctrl_if kbd();

    ps2_kbd_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kbd (kbd)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        kbd.in_valid = 1'b0;
        kbd.evt_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [7:0] c, input logic pe, input logic fe);
        kbd.in_valid      = 1'b1;
        kbd.in_code       = c;
        kbd.in_parity_err = pe;
        kbd.in_frame_err  = fe;
        @(negedge clk);
        kbd.in_valid      = 1'b0;
        kbd.in_parity_err = 1'b0;
        kbd.in_frame_err  = 1'b0;
    endtask

    task automatic pop_evt(output logic v, output logic [9:0] e);
        v = kbd.evt_valid;
        e = {kbd.evt_ext, kbd.evt_break, kbd.evt_code};
        kbd.evt_ready = 1'b1;
        @(negedge clk);
        kbd.evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        kbd.in_valid = 1'b0;
        kbd.in_code = 8'h00;
        kbd.in_parity_err = 1'b0;
        kbd.in_frame_err = 1'b0;
        kbd.evt_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", kbd.evt_valid);
        end
        n_tests++;
        if ({kbd.evt_ext, kbd.evt_break, kbd.evt_code} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_evt: got %h want 000",
                     {kbd.evt_ext, kbd.evt_break, kbd.evt_code});
        end
        n_tests++;
        if (kbd.overflow !== 1'b0 || kbd.err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got ovf=%b err=%h want 0 00",
                     kbd.overflow, kbd.err_cnt);
        end
    endtask

    task automatic test_make_break();
        logic [7:0] seq [8];
        logic [9:0] exp [4];
        logic       v;
        logic [9:0] e;
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        exp = '{10'h01C, 10'h11C, 10'h275, 10'h375};
        do_reset();
        for (int i = 0; i < 8; i++) drive(seq[i], 1'b0, 1'b0);
        n_tests++;
        if (kbd.err_cnt !== 8'h00 || kbd.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mb_flags: got err=%h ovf=%b want 00 0",
                     kbd.err_cnt, kbd.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(v, e);
            n_tests++;
            if (v !== 1'b1 || e !== exp[i]) begin
                n_fail++;
                $display("FAIL mb_evt%0d: got v=%b e=%h want v=1 e=%h",
                         i, v, e, exp[i]);
            end
        end
        n_tests++;
        if (kbd.evt_valid !== 1'b0 ||
            {kbd.evt_ext, kbd.evt_break, kbd.evt_code} !== 10'h000) begin
            n_fail++;
            $display("FAIL mb_empty: got v=%b e=%h want 0 000", kbd.evt_valid,
                     {kbd.evt_ext, kbd.evt_break, kbd.evt_code});
        end
    endtask

    task automatic test_bad_byte();
        logic       v;
        logic [9:0] e;
        do_reset();
        drive(8'h1C, 1'b1, 1'b0);
        drive(8'h1C, 1'b0, 1'b0);
        n_tests++;
        if (kbd.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL bad_err: got %h want 01", kbd.err_cnt);
        end
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h01C) begin
            n_fail++;
            $display("FAIL bad_evt: got v=%b e=%h want v=1 e=01C", v, e);
        end
        drive(8'hF0, 1'b0, 1'b0);
        drive(8'h2C, 1'b0, 1'b1);
        drive(8'hFF, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h3C, 1'b0, 1'b0);
        n_tests++;
        if (kbd.err_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL bad_err2: got %h want 04", kbd.err_cnt);
        end
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h03C || kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_evt2: got v=%b e=%h after=%b want 1 03C 0",
                     v, e, kbd.evt_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] seq [6];
        logic       v;
        logic [9:0] e;
        seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        do_reset();
        for (int i = 0; i < 6; i++) drive(seq[i], 1'b0, 1'b0);
        n_tests++;
        if (kbd.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b want 1", kbd.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(v, e);
            n_tests++;
            if (v !== 1'b1 || e !== {2'b00, seq[i]}) begin
                n_fail++;
                $display("FAIL ovf_evt%0d: got v=%b e=%h want v=1 e=%h",
                         i, v, e, {2'b00, seq[i]});
            end
        end
        n_tests++;
        if (kbd.evt_valid !== 1'b0 || kbd.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_end: got v=%b ovf=%b want 0 1",
                     kbd.evt_valid, kbd.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        logic       v;
        logic [9:0] e;
        exp = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
        do_reset();
        drive(8'h15, 1'b0, 1'b0);
        drive(8'h1D, 1'b0, 1'b0);
        drive(8'h24, 1'b0, 1'b0);
        drive(8'h2D, 1'b0, 1'b0);
        kbd.evt_ready = 1'b1;
        drive(8'h3C, 1'b0, 1'b0);
        kbd.evt_ready = 1'b0;
        n_tests++;
        if (kbd.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_ovf: got %b want 0", kbd.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(v, e);
            n_tests++;
            if (v !== 1'b1 || e !== {2'b00, exp[i]}) begin
                n_fail++;
                $display("FAIL fpp_evt%0d: got v=%b e=%h want v=1 e=%h",
                         i, v, e, {2'b00, exp[i]});
            end
        end
        n_tests++;
        if (kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_empty: got %b want 0", kbd.evt_valid);
        end
    endtask

    task automatic test_empty_push_pop();
        logic       v;
        logic [9:0] e;
        do_reset();
        kbd.evt_ready = 1'b1;
        drive(8'h4B, 1'b0, 1'b0);
        kbd.evt_ready = 1'b0;
        n_tests++;
        if (kbd.evt_valid !== 1'b1 || kbd.evt_code !== 8'h4B) begin
            n_fail++;
            $display("FAIL epp_evt: got v=%b c=%h want 1 4B",
                     kbd.evt_valid, kbd.evt_code);
        end
        pop_evt(v, e);
        n_tests++;
        if (kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL epp_empty: got %b want 0", kbd.evt_valid);
        end
    endtask

    task automatic test_prefix_abandon();
        logic       v;
        logic [9:0] e;
        do_reset();
        drive(8'hE0, 1'b0, 1'b0);
        drive(8'hE0, 1'b0, 1'b0);
        drive(8'hF0, 1'b0, 1'b0);
        drive(8'h6B, 1'b0, 1'b0);
        n_tests++;
        if (kbd.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL abn_err: got %h want 01", kbd.err_cnt);
        end
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h36B || kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abn_evt: got v=%b e=%h after=%b want 1 36B 0",
                     v, e, kbd.evt_valid);
        end
        drive(8'hF0, 1'b0, 1'b0);
        drive(8'hF0, 1'b0, 1'b0);
        drive(8'h1C, 1'b0, 1'b0);
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h11C || kbd.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL dup_f0: got v=%b e=%h err=%h want 1 11C 01",
                     v, e, kbd.err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic       v;
        logic [9:0] e;
        do_reset();
        drive(8'h15, 1'b0, 1'b0);
        drive(8'hF0, 1'b0, 1'b0);
        do_reset();
        n_tests++;
        if (kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_flush: got %b want 0", kbd.evt_valid);
        end
        drive(8'h1C, 1'b0, 1'b0);
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h01C) begin
            n_fail++;
            $display("FAIL rmid_evt: got v=%b e=%h want 1 01C", v, e);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) drive(8'h00, 1'b0, 1'b0);
        n_tests++;
        if (kbd.err_cnt !== 8'hFF || kbd.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sat: got err=%h v=%b want FF 0",
                     kbd.err_cnt, kbd.evt_valid);
        end
    endtask

`ifdef PS2_KBD_TIMEOUT_EN
    task automatic test_timeout();
        logic       v;
        logic [9:0] e;
        do_reset();
        drive(8'hF0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        drive(8'h1C, 1'b0, 1'b0);
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h01C || kbd.err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL tmo_hit: got v=%b e=%h err=%h want 1 01C 01",
                     v, e, kbd.err_cnt);
        end
        do_reset();
        drive(8'hF0, 1'b0, 1'b0);
        repeat (99) @(negedge clk);
        drive(8'h1C, 1'b0, 1'b0);
        pop_evt(v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 10'h11C || kbd.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL tmo_edge: got v=%b e=%h err=%h want 1 11C 00",
                     v, e, kbd.err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_make_break();
        test_bad_byte();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_prefix_abandon();
        test_reset_mid();
        test_err_saturate();
`ifdef PS2_KBD_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
